shifter_seq: RTL and testbench
==============================

// Module: shifter_seq
// PURPOSE
//  Multi-cycle, parametrised shifter/rotator for the ALU datapath. Accepts an operand, amount and
//  op on a start pulse, shifts STEP bit positions per clock, and returns the result with a one-cycle
//  done pulse. Trades latency for area against the single-cycle combinational shifter. Adds
//  registered operation, a handshake, shift amounts >= WIDTH and optional rotates.
// PARAMETERS
//  WIDTH        32  operand/result width in bits (>= 2)
//  SHIFT_WIDTH   5  width of i_shift; may exceed clog2(WIDTH)
//  STEP          4  max bit positions shifted per clock (1..WIDTH)
// PORTS
//  i_clk     in   1            clock, rising edge
//  i_rst     in   1            asynchronous, active-high reset
//  i_data    in   WIDTH        operand, sampled on accepted start
//  i_shift   in   SHIFT_WIDTH  shift amount n (unsigned), sampled on accepted start
//  i_op      in   3            000 SLA, 001 SLL, 010 SRA, 011 SRL, 100 ROL, 101 ROR, 11x invalid
//  i_start   in   1            request; accepted only when o_busy==0
//  o_busy    out  1            operation in progress
//  o_done    out  1            one-cycle pulse; o_result valid from this cycle
//  o_result  out  WIDTH        last completed result, held until next completion
// BEHAVIOUR
//  - Reset (async assert): state IDLE, o_busy=0, o_done=0, o_result=0, internal regs cleared.
//    Reset mid-operation aborts it with no done pulse.
//  - FSM states: IDLE -> RUN on accepted start. RUN -> IDLE when the remaining count reaches 0,
//    with o_done=1 for that one cycle. done is not a separate state.
//  - Start accepted on edge E0 when i_start=1 and o_busy=0, including the o_done cycle
//    (back-to-back). i_start while o_busy=1 is ignored with no side effects.
//  - At E0: latch work=i_data, rem=n, op, sign=i_data[WIDTH-1]. o_busy=1 after E0.
//  - Each RUN edge: shift work by s=min(rem,STEP), then rem-=s.
//  - Latency: k=max(1,ceil(n/STEP)) edges after E0. At Ek: o_result=final, o_done=1, o_busy=0.
//    n=0 takes 1 cycle and returns i_data unchanged.
//  - o_result changes only at completion; it holds the previous value while RUN.
//  - SLL/SRL: zero fill. n>=WIDTH -> 0.
//  - SRA: fill with the latched sign. n>=WIDTH -> all bits = sign.
//  - SLA: bit WIDTH-1 keeps the latched sign; bits WIDTH-2:0 = (i_data<<n)[WIDTH-2:0].
//    n>=WIDTH-1 -> {sign, 0...}.
//  - ROL/ROR: circular; effective amount is n mod WIDTH. Any n is legal.
//  - Invalid op (11x, or 10x without the macro): pass-through, o_result=i_data, latency 1.
//  - Simultaneous reset and start: reset wins.
// CONFIGURATION
//  SHIFTER_SEQ_ROTATE_EN
//  - Defined: ops 100 (ROL) and 101 (ROR) are implemented as above.
//  - Undefined: the rotate logic is removed. 100/101 behave as invalid ops (pass-through,
//    1-cycle latency).
//  - All other behaviour is identical in both builds.
// TESTING  (WIDTH=32, SHIFT_WIDTH=5, STEP=4)
//  - SLL 0x0000_0001, n=31 -> o_result=0x8000_0000. o_done exactly 8 cycles after start;
//    o_busy high for those 8 cycles.
//  - SRA 0x8000_00F0, n=4 -> 0xF800_000F, done after 1 cycle.
//    SRL with the same inputs -> 0x0800_000F.
//  - SRL 0xDEAD_BEEF, n=0 -> 0xDEAD_BEEF, done after 1 cycle.
//    SLA 0x8000_0001, n=1 -> 0x8000_0002.
//  - ROR 0x0000_0001, n=1 -> 0x8000_0000 with the macro defined;
//    0x0000_0001 (pass-through) without it.
//  - Start SLL n=31, pulse i_start again at cycle 3 -> ignored, single done at cycle 8.
//    New start in the done cycle -> accepted, second done follows.
//  - Start SLL n=31, assert i_rst at cycle 4 -> o_busy=0, o_done=0, o_result=0 immediately.
//    No done pulse afterwards.

Source files
------------

// File: rtl/shifter_seq_if.sv
// Purpose : request/response bundle between an ALU sequencer and the multi-cycle shifter.
// Ports   : i_data/i_shift/i_op/i_start flow master->slave; o_busy/o_done/o_result flow slave->master.
// Modports: master drives the request and observes status; slave is the shifter side.
interface shifter_seq_if #(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5
);
    logic [WIDTH-1:0]       i_data;
    logic [SHIFT_WIDTH-1:0] i_shift;
    logic [2:0]             i_op;
    logic                   i_start;
    logic                   o_busy;
    logic                   o_done;
    logic [WIDTH-1:0]       o_result;

    modport master (
        output i_data, i_shift, i_op, i_start,
        input  o_busy, o_done, o_result
    );

    modport slave (
        input  i_data, i_shift, i_op, i_start,
        output o_busy, o_done, o_result
    );
endinterface

// File: rtl/shifter_seq.sv
// Purpose : multi-cycle shifter/rotator (SLA/SLL/SRA/SRL, optional ROL/ROR), STEP bit positions per clock.
// Latency : max(1, ceil(n/STEP)) clocks from accepted start to the o_done pulse; invalid ops take 1.
// Backpr. : i_start is accepted only while o_busy==0 (including the o_done cycle); starts while busy are dropped.
// Ports   : i_clk, i_rst (async, active high) plus bus (shifter_seq_if.slave) carrying the request and result.
// Config  : define SHIFTER_SEQ_ROTATE_EN to build the ROL/ROR datapath; otherwise 100/101 are pass-through.
module shifter_seq #(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5,
    parameter int STEP        = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    shifter_seq_if.slave  bus
);

    // The remaining-count register must hold both any i_shift value and STEP itself.
    localparam int SCW = $clog2(STEP + 1);
    localparam int RW  = (SHIFT_WIDTH > SCW) ? SHIFT_WIDTH : SCW;
    localparam logic [RW-1:0] STEP_R = RW'(STEP);

    localparam logic [2:0] OP_SLA = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
`ifdef SHIFTER_SEQ_ROTATE_EN
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic [RW-1:0]    step_amt;
    logic [WIDTH-1:0] sh_l, sh_r, sra_fill, step_res;
    logic             op_ok;
`ifdef SHIFTER_SEQ_ROTATE_EN
    logic [31:0]      back_amt;
`endif

    // Ops outside the implemented set are loaded with a zero count so they
    // complete on the first RUN edge with the operand untouched.
    always_comb begin
        op_ok = 1'b0;
        case (bus.i_op)
            OP_SLA, OP_SLL, OP_SRA, OP_SRL: op_ok = 1'b1;
`ifdef SHIFTER_SEQ_ROTATE_EN
            OP_ROL, OP_ROR:                 op_ok = 1'b1;
`endif
            default:                        op_ok = 1'b0;
        endcase
    end

    // One step of the datapath: shift by min(rem, STEP). Shifting past WIDTH
    // across several steps naturally saturates to the fill pattern, and
    // rotating n positions one chunk at a time yields n mod WIDTH.
    always_comb begin
        step_amt = (rem_q > STEP_R) ? STEP_R : rem_q;
        sh_l     = work_q << step_amt;
        sh_r     = work_q >> step_amt;
        sra_fill = sign_q ? ~({WIDTH{1'b1}} >> step_amt) : '0;
`ifdef SHIFTER_SEQ_ROTATE_EN
        // A zero step gives back_amt == WIDTH, which shifts everything out.
        back_amt = 32'(WIDTH) - 32'(step_amt);
`endif
        step_res = work_q;
        case (op_q)
            OP_SLA:  step_res = {sign_q, sh_l[WIDTH-2:0]};
            OP_SLL:  step_res = sh_l;
            OP_SRA:  step_res = sh_r | sra_fill;
            OP_SRL:  step_res = sh_r;
`ifdef SHIFTER_SEQ_ROTATE_EN
            OP_ROL:  step_res = sh_l | (work_q >> back_amt);
            OP_ROR:  step_res = sh_r | (work_q << back_amt);
`endif
            default: step_res = work_q;
        endcase
    end

    // Next-state logic. Completion is the RUN edge whose step consumes the
    // last of the count; done is a registered pulse, not a separate state.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        op_d     = op_q;
        sign_d   = sign_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    work_d  = bus.i_data;
                    rem_d   = op_ok ? RW'(bus.i_shift) : '0;
                    op_d    = bus.i_op;
                    sign_d  = bus.i_data[WIDTH-1];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = step_res;
                rem_d  = rem_q - step_amt;
                if (rem_q == step_amt) begin
                    result_d = step_res;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.o_busy   = (state_q == ST_RUN);
    assign bus.o_done   = done_q;
    assign bus.o_result = result_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Purpose : directed checks of shifter_seq (WIDTH=32, SHIFT_WIDTH=5, STEP=4) against hand-computed results.
// Latency : n/a (bench).
// Backpr. : n/a (bench); exercises ignored starts, back-to-back starts and reset abort.
module tb_shifter_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef SHIFTER_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    shifter_seq_if #(.WIDTH(32), .SHIFT_WIDTH(5)) bus ();

    shifter_seq #(.WIDTH(32), .SHIFT_WIDTH(5), .STEP(4)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for its done pulse; checks result,
    // latency in edges after acceptance, busy duration and busy low at done.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] n,
                          input logic [2:0] op, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        int busy_n;
        bus.i_data  = d;
        bus.i_shift = n;
        bus.i_op    = op;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!bus.o_done && lat < 64) begin
            if (bus.o_busy) busy_n++;
            tick();
            lat++;
        end
        chk({tag, ".res"},  bus.o_result, exp_r);
        chk({tag, ".lat"},  32'(lat),     32'(exp_lat));
        chk({tag, ".busy"}, 32'(busy_n),  32'(exp_lat));
        chk({tag, ".idle"}, {31'd0, bus.o_busy}, 32'd0);
    endtask

    initial begin
        int dn;
        bus.i_data  = '0;
        bus.i_shift = '0;
        bus.i_op    = '0;
        bus.i_start = 1'b0;
        #1 rst = 1'b1;
        tick();
        chk("rst.busy",   {31'd0, bus.o_busy}, 32'd0);
        chk("rst.done",   {31'd0, bus.o_done}, 32'd0);
        chk("rst.result", bus.o_result,        32'd0);
        rst = 1'b0;
        tick();

        run_op("sll31",   32'h0000_0001, 5'd31, 3'b001, 32'h8000_0000, 8);
        run_op("sra4",    32'h8000_00F0, 5'd4,  3'b010, 32'hF800_000F, 1);
        run_op("srl4",    32'h8000_00F0, 5'd4,  3'b011, 32'h0800_000F, 1);
        run_op("srl0",    32'hDEAD_BEEF, 5'd0,  3'b011, 32'hDEAD_BEEF, 1);
        run_op("sla1",    32'h8000_0001, 5'd1,  3'b000, 32'h8000_0002, 1);
        run_op("ror1",    32'h0000_0001, 5'd1,  3'b101, ROT ? 32'h8000_0000 : 32'h0000_0001, 1);
        run_op("rol4",    32'h8000_0001, 5'd4,  3'b100, ROT ? 32'h0000_0018 : 32'h8000_0001, 1);
        run_op("rol8",    32'h1234_5678, 5'd8,  3'b100, ROT ? 32'h3456_7812 : 32'h1234_5678, ROT ? 2 : 1);
        run_op("sra31",   32'h8000_0000, 5'd31, 3'b010, 32'hFFFF_FFFF, 8);
        run_op("sla31",   32'hFFFF_FFFF, 5'd31, 3'b000, 32'h8000_0000, 8);
        run_op("srl9",    32'hF000_0000, 5'd9,  3'b011, 32'h0078_0000, 3);
        run_op("inval",   32'h1234_5678, 5'd20, 3'b110, 32'h1234_5678, 1);

        // Start ignored while busy, then a back-to-back start in the done cycle.
        bus.i_data  = 32'h0000_0001;
        bus.i_shift = 5'd31;
        bus.i_op    = 3'b001;
        bus.i_start = 1'b1;
        tick();                         // E0
        bus.i_start = 1'b0;
        tick();                         // E1
        tick();                         // E2
        bus.i_data  = 32'hFFFF_0000;
        bus.i_shift = 5'd0;
        bus.i_op    = 3'b011;
        bus.i_start = 1'b1;
        tick();                         // E3: must be ignored
        bus.i_start = 1'b0;
        chk("ign.busy", {31'd0, bus.o_busy}, 32'd1);
        chk("ign.hold", bus.o_result, 32'h1234_5678);
        dn = 0;
        for (int i = 4; i < 8; i++) begin
            tick();
            if (bus.o_done) dn++;
        end
        chk("ign.early_done", 32'(dn), 32'd0);
        tick();                         // E8
        chk("ign.done8", {31'd0, bus.o_done}, 32'd1);
        chk("ign.res",   bus.o_result, 32'h8000_0000);
        bus.i_data  = 32'hDEAD_BEEF;
        bus.i_shift = 5'd0;
        bus.i_op    = 3'b011;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick();
        chk("b2b.done", {31'd0, bus.o_done}, 32'd1);
        chk("b2b.res",  bus.o_result, 32'hDEAD_BEEF);
        tick();
        chk("b2b.quiet", {30'd0, bus.o_done, bus.o_busy}, 32'd0);

        // Reset in the middle of a long operation aborts it silently.
        bus.i_data  = 32'h0000_0001;
        bus.i_shift = 5'd31;
        bus.i_op    = 3'b001;
        bus.i_start = 1'b1;
        tick();                         // E0
        bus.i_start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort.busy",   {31'd0, bus.o_busy}, 32'd0);
        chk("abort.done",   {31'd0, bus.o_done}, 32'd0);
        chk("abort.result", bus.o_result,        32'd0);
        tick();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.o_done || bus.o_busy) dn++;
        end
        chk("abort.silent", 32'(dn), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
